// File: rtl/adaptive_filter_pkg.sv
// Shared sample and framer entry types for the adaptive filter datapath.
// Sample format is signed Q(WORDLENGTH-FRACTIONAL_LENGTH).FRACTIONAL_LENGTH.
package adaptive_filter_pkg;

  localparam int WORDLENGTH        = 14;
  localparam int FRACTIONAL_LENGTH = 6;

  typedef logic signed [WORDLENGTH-1:0] filter_sample_t;

  typedef struct packed {
    logic           tuser;
    filter_sample_t data;
  } framer_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with the head read straight from the storage flops,
// so data written at one edge is visible right after it.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_wr, do_rd;

  // Extra pointer MSB separates full from empty when low bits match
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count   = wr_ptr_q - rd_ptr_q;
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_rd    = rd_en && !empty;
    do_wr    = wr_en && (!full || do_rd);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (do_wr) begin
      mem_d[wr_ptr_q[AW-1:0]] = wr_data;
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/adaptive_filter_out_framer.sv
// Buffers the non-stallable filter stream and re-emits it as AXI-Stream
// with tlast framing, tuser discontinuity marks and drop accounting.
module adaptive_filter_out_framer #(
  parameter int WORDLENGTH        = 14,
  parameter int FRACTIONAL_LENGTH = 6,
  parameter int FIFO_DEPTH        = 16,
  parameter int FRAME_LEN         = 128,
  parameter int DROP_CNT_W        = 16
) (
  input  logic                          clk,
  input  logic                          srst,
  input  logic [WORDLENGTH-1:0]         s_tdata,
  input  logic                          s_tvalid,
  output logic [WORDLENGTH-1:0]         m_tdata,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic                          m_tlast,
  output logic                          m_tuser,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level,
  output logic                          overflow,
  output logic [DROP_CNT_W-1:0]         drop_cnt
);

  import adaptive_filter_pkg::*;

  localparam int FCW = $clog2(FRAME_LEN);
  localparam int EW  = $bits(framer_entry_t);

  framer_entry_t           wr_entry, rd_entry;
  logic                    fifo_full, fifo_empty;
  logic                    pop, wr_en, drop, frame_end;
  logic                    drop_pending_q, drop_pending_d;
  logic                    overflow_q, overflow_d;
  logic [DROP_CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic [FCW-1:0]          frame_cnt_q, frame_cnt_d;

  // Fixed-point format is metadata only; data passes through bit-exact
  logic unused_fmt;
  assign unused_fmt = (FRACTIONAL_LENGTH > 0);

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .srst    (srst),
    .wr_en   (wr_en),
    .wr_data (wr_entry),
    .rd_en   (pop),
    .rd_data (rd_entry),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fill_level)
  );

  always_comb begin
    pop            = !fifo_empty && m_tready;
    wr_en          = s_tvalid && (!fifo_full || pop);
    drop           = s_tvalid && !wr_en;
    frame_end      = (frame_cnt_q == FCW'(FRAME_LEN-1));
    wr_entry.tuser = drop_pending_q;
    wr_entry.data  = filter_sample_t'(s_tdata);

    drop_pending_d = drop_pending_q;
    if (drop) begin
      drop_pending_d = 1'b1;
    end else if (wr_en) begin
      drop_pending_d = 1'b0;
    end

    overflow_d = overflow_q | drop;
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
    end

    frame_cnt_d = frame_cnt_q;
    if (pop) begin
      frame_cnt_d = frame_end ? '0 : frame_cnt_q + FCW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      drop_pending_q <= 1'b0;
      overflow_q     <= 1'b0;
      drop_cnt_q     <= '0;
      frame_cnt_q    <= '0;
    end else begin
      drop_pending_q <= drop_pending_d;
      overflow_q     <= overflow_d;
      drop_cnt_q     <= drop_cnt_d;
      frame_cnt_q    <= frame_cnt_d;
    end
  end

  assign m_tvalid = !fifo_empty;
  assign m_tdata  = m_tvalid ? rd_entry.data : '0;
  assign m_tuser  = m_tvalid && rd_entry.tuser;
  assign m_tlast  = m_tvalid && frame_end;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_adaptive_filter_out_framer.sv
// Directed bench for adaptive_filter_out_framer; a second instance with a
// 3-bit drop counter shares the stimulus to exercise saturation.
module tb_adaptive_filter_out_framer;

  localparam int WL = 14;

  logic          clk, srst, s_tvalid, m_tready;
  logic [WL-1:0] s_tdata;
  logic [WL-1:0] m_tdata, m_tdata_s;
  logic          m_tvalid, m_tlast, m_tuser, overflow;
  logic          m_tvalid_s, m_tlast_s, m_tuser_s, overflow_s;
  logic [4:0]    fill_level, fill_level_s;
  logic [15:0]   drop_cnt;
  logic [2:0]    drop_cnt_s;

  int checks = 0;
  int errors = 0;

  adaptive_filter_out_framer dut (
    .clk        (clk),
    .srst       (srst),
    .s_tdata    (s_tdata),
    .s_tvalid   (s_tvalid),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tlast    (m_tlast),
    .m_tuser    (m_tuser),
    .fill_level (fill_level),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt)
  );

  adaptive_filter_out_framer #(.DROP_CNT_W(3)) dut_s (
    .clk        (clk),
    .srst       (srst),
    .s_tdata    (s_tdata),
    .s_tvalid   (s_tvalid),
    .m_tdata    (m_tdata_s),
    .m_tvalid   (m_tvalid_s),
    .m_tready   (m_tready),
    .m_tlast    (m_tlast_s),
    .m_tuser    (m_tuser_s),
    .fill_level (fill_level_s),
    .overflow   (overflow_s),
    .drop_cnt   (drop_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pass_frame(input int base);
    m_tready = 1'b1;
    s_tvalid = 1'b1;
    for (int i = 0; i < 128; i++) begin
      s_tdata = WL'(base + i);
      step();
      chk("pt_data", 32'(m_tdata), (base + i) & 'h3FFF);
      chk("pt_tlast", 32'(m_tlast), 32'(i == 127));
      chk("pt_tuser", 32'(m_tuser), 0);
      chk("pt_fill", 32'(fill_level), 1);
    end
    s_tvalid = 1'b0;
    step();
    chk("pt_drain_valid", 32'(m_tvalid), 0);
    chk("pt_drain_fill", 32'(fill_level), 0);
  endtask

  logic [WL-1:0] v2 [5];
  int            e;

  initial begin
    v2 = '{14'h1FFF, 14'h2000, 14'd1, 14'd2, 14'd3};
    srst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b0;
    step();
    step();
    chk("rst_valid", 32'(m_tvalid), 0);
    chk("rst_data", 32'(m_tdata), 0);
    chk("rst_last", 32'(m_tlast), 0);
    chk("rst_user", 32'(m_tuser), 0);
    chk("rst_fill", 32'(fill_level), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    srst = 1'b0;
    step();

    // 1: pass-through ramp, one full frame
    pass_frame(0);
    chk("t1_ovf", 32'(overflow), 0);
    chk("t1_drop", 32'(drop_cnt), 0);

    // 2: backpressure hold then ordered drain
    m_tready = 1'b0;
    s_tvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_tdata = v2[i];
      step();
    end
    s_tvalid = 1'b0;
    chk("t2_fill", 32'(fill_level), 5);
    chk("t2_valid", 32'(m_tvalid), 1);
    chk("t2_head", 32'(m_tdata), 'h1FFF);
    step();
    chk("t2_hold", 32'(m_tdata), 'h1FFF);
    chk("t2_hold_fill", 32'(fill_level), 5);
    m_tready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t2_drain", 32'(m_tdata), 32'(v2[i]));
      chk("t2_drain_last", 32'(m_tlast), 0);
      step();
    end
    chk("t2_empty", 32'(m_tvalid), 0);

    // 3: overflow, then tuser on the first sample after the drops
    m_tready = 1'b0;
    s_tvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s_tdata = WL'(100 + i);
      step();
    end
    chk("t3_fill", 32'(fill_level), 16);
    chk("t3_drop", 32'(drop_cnt), 4);
    chk("t3_ovf", 32'(overflow), 1);
    chk("t3_head", 32'(m_tdata), 100);
    chk("t3_head_user", 32'(m_tuser), 0);
    s_tdata = 14'h0AA;
    m_tready = 1'b1;
    step();
    s_tvalid = 1'b0;
    chk("t3_fill_pop", 32'(fill_level), 16);
    chk("t3_drop_pop", 32'(drop_cnt), 4);
    for (int k = 1; k <= 16; k++) begin
      e = (k < 16) ? 100 + k : 'hAA;
      chk("t3_data", 32'(m_tdata), e);
      chk("t3_user", 32'(m_tuser), 32'(k == 16));
      step();
    end
    chk("t3_empty", 32'(m_tvalid), 0);

    // 4: full FIFO with concurrent pop and write
    m_tready = 1'b0;
    s_tvalid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s_tdata = WL'(200 + i);
      step();
    end
    chk("t4_full", 32'(fill_level), 16);
    chk("t4_user", 32'(m_tuser), 0);
    m_tready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      s_tdata = WL'(300 + j);
      step();
      chk("t4_fill", 32'(fill_level), 16);
      chk("t4_drop", 32'(drop_cnt), 4);
    end
    s_tvalid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      e = (k < 12) ? 204 + k : 300 + k - 12;
      chk("t4_data", 32'(m_tdata), e);
      step();
    end
    chk("t4_empty", 32'(m_tvalid), 0);

    // 5: reset mid-frame with data still buffered
    s_tvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      s_tdata = WL'(i);
      step();
    end
    s_tvalid = 1'b0;
    step();
    m_tready = 1'b0;
    s_tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_tdata = WL'(500 + i);
      step();
    end
    s_tvalid = 1'b0;
    chk("t5_fill_pre", 32'(fill_level), 3);
    srst = 1'b1;
    step();
    chk("t5_valid", 32'(m_tvalid), 0);
    chk("t5_data", 32'(m_tdata), 0);
    chk("t5_last", 32'(m_tlast), 0);
    chk("t5_user", 32'(m_tuser), 0);
    chk("t5_fill", 32'(fill_level), 0);
    chk("t5_ovf", 32'(overflow), 0);
    chk("t5_drop", 32'(drop_cnt), 0);
    srst = 1'b0;
    step();
    pass_frame(1000);

    // 6: drop counter saturation on the narrow instance
    srst = 1'b1;
    step();
    srst = 1'b0;
    m_tready = 1'b0;
    s_tvalid = 1'b1;
    for (int i = 0; i < 22; i++) begin
      s_tdata = WL'(i);
      step();
    end
    chk("t6_pre_sat", 32'(drop_cnt_s), 6);
    for (int i = 0; i < 4; i++) begin
      step();
    end
    s_tvalid = 1'b0;
    chk("t6_sat", 32'(drop_cnt_s), 7);
    chk("t6_sat_ovf", 32'(overflow_s), 1);
    chk("t6_wide", 32'(drop_cnt), 10);
    chk("t6_fill", 32'(fill_level), 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adaptive_filter_out_framer.md
Name: adaptive_filter_out_framer

Overview:
- Sits directly downstream of adaptive_filter and consumes its valid-only m_tdata/m_tvalid stream.
- adaptive_filter cannot stall, so this block buffers samples in a FIFO and re-emits them as an AXI-Stream master with tready backpressure.
- Marks frame ends with tlast every FRAME_LEN delivered samples.
- Flags discontinuities with tuser and counts samples dropped on overflow.

Parameters:
- WORDLENGTH, 14, sample width (signed Q format, same as the filter).
- FRACTIONAL_LENGTH, 6, fractional bits; informational only, data is passed through untouched.
- FIFO_DEPTH, 16, buffer entries; power of two, ≥ 2.
- FRAME_LEN, 128, delivered samples per frame; ≥ 2.
- DROP_CNT_W, 16, width of the saturating drop counter.

Ports:
- clk  in  1  clock
- srst  in  1  synchronous reset, active-high
- s_tdata  in  WORDLENGTH  sample from adaptive_filter
- s_tvalid  in  1  sample valid; no ready, every valid cycle is a sample
- m_tdata  out  WORDLENGTH  buffered sample
- m_tvalid  out  1  output valid
- m_tready  in  1  downstream ready
- m_tlast  out  1  last sample of frame
- m_tuser  out  1  first sample delivered after one or more drops
- fill_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- overflow  out  1  sticky, set on the first drop
- drop_cnt  out  DROP_CNT_W  dropped samples, saturating at all-ones

Behaviour:
- Reset: clk is the clock; srst is synchronous, active-high.
  - All outputs are 0 during and after reset: m_tvalid, m_tlast, m_tuser, m_tdata, fill_level, overflow, drop_cnt.
  - FIFO pointers, frame counter and drop_pending are cleared.
  - Reset asserted mid-frame discards buffered data; the next delivered sample is frame index 0.
- Write: when s_tvalid=1, the sample is written if the FIFO is not full, or if it is full and a pop occurs in the same cycle (m_tvalid && m_tready). In both cases the write is accepted.
- Drop: otherwise the sample is dropped.
  - overflow is set and stays set until srst.
  - drop_cnt increments and saturates at 2^DROP_CNT_W-1.
  - drop_pending is set.
- tuser tagging: each FIFO entry stores {tuser, data}. A written sample takes tuser=drop_pending, and drop_pending clears on that write.
- Latency: with the FIFO empty, a sample written at edge N produces m_tvalid=1 with that data after edge N. Output is registered (first-word-fall-through on a registered head), so the latency is 1 cycle.
- Handshake:
  - m_tvalid, m_tdata, m_tuser and m_tlast hold stable while m_tvalid && !m_tready.
  - m_tvalid never deasserts without a transfer.
  - Pop happens only on m_tvalid && m_tready.
- Frame counter:
  - Counts transfers (pops) modulo FRAME_LEN.
  - m_tlast = (frame_cnt == FRAME_LEN-1) while m_tvalid.
  - Dropped samples are not counted, so frames always contain exactly FRAME_LEN delivered samples.
- fill_level: occupancy after the edge. Simultaneous write and pop leaves it unchanged. Range 0..FIFO_DEPTH.
- Pointer wrap: pointers wrap modulo FIFO_DEPTH. Full/empty is resolved by the extra MSB in the pointers.
- Empty FIFO with m_tready=1: m_tvalid stays 0 and no pop occurs.
- Data handling: data is not modified; sign and fixed-point format are preserved bit-exact.

Decomposition:
- adaptive_filter_pkg holds:
  - WORDLENGTH=14 and FRACTIONAL_LENGTH=6.
  - typedef filter_sample_t (logic signed [WORDLENGTH-1:0]).
  - typedef framer_entry_t (struct: tuser bit + filter_sample_t).
- Sub-module sync_fifo:
  - Parameterised width/depth, registered head, full/empty/count outputs.
  - Instantiated with the width of framer_entry_t.
- The top level holds the write/drop logic, drop_pending, drop_cnt, overflow and frame counter.

Test Plan:
1. Pass-through: after reset, s_tvalid=1 for 128 cycles with ramp 0..127 and m_tready=1. Expected:
   - m_tdata = 0..127, each 1 cycle after input.
   - m_tlast only on value 127.
   - m_tuser=0, overflow=0, drop_cnt=0, fill_level ≤ 1.
2. Backpressure hold: m_tready=0 while 5 samples (0x1FFF, 0x2000, 1, 2, 3) are written. Expected:
   - fill_level=5, m_tvalid=1, m_tdata=0x1FFF stable.
   - Raising m_tready drains in order over 5 cycles.
3. Overflow: m_tready=0, s_tvalid=1 for 20 cycles with FIFO_DEPTH=16. Expected:
   - fill_level=16, drop_cnt=4, overflow=1.
   - Then write 0x0AA with m_tready=1: the first 16 outputs have tuser=0, and 0x0AA is delivered with m_tuser=1.
4. Full with concurrent pop: FIFO full, m_tready=1, s_tvalid=1. Expected: no drop, fill_level stays 16, drop_cnt unchanged.
5. Reset mid-frame: deliver 50 samples, hold 3 in the FIFO, assert srst for 1 cycle. Expected:
   - All outputs 0, fill_level=0, overflow=0.
   - The next 128 delivered samples have m_tlast only on the 128th.
6. Saturation: DROP_CNT_W=3, force 10 drops. Expected: drop_cnt=7 and overflow=1.
